// File: rtl/gen_gamma_pkg.sv
// Shared types, default LFSR constants and a reference word-advance function
// for the gen_gamma keystream path.
package gen_gamma_pkg;

  typedef enum logic [1:0] {IDLE, WARM, RUN, EXPIRED} gamma_state_t;

  localparam int unsigned             DEF_LFSR_W = 16;
  localparam logic [DEF_LFSR_W-1:0]   DEF_TAPS   = 16'hB400;

  // Right-shifting Galois LFSR advanced by 'steps' single-bit steps.
  function automatic logic [DEF_LFSR_W-1:0] lfsr_word(input logic [DEF_LFSR_W-1:0] s_in,
                                                      input int unsigned           steps);
    logic [DEF_LFSR_W-1:0] s;
    s = s_in;
    for (int unsigned i = 0; i < steps; i++) begin
      if (s[0]) s = (s >> 1) ^ DEF_TAPS;
      else      s = s >> 1;
    end
    return s;
  endfunction

endpackage

// File: rtl/lfsr_word_step.sv
// Purely combinational advance of a Galois LFSR by SIZE steps, unrolled
// into a single cycle.
module lfsr_word_step #(
  parameter int unsigned        LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  TAPS   = 16'hB400,
  parameter int unsigned        SIZE   = 8
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] s;

  always_comb begin
    s = state_i;
    for (int unsigned i = 0; i < SIZE; i++) begin
      s = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? TAPS : '0);
    end
    state_o = s;
  end

endmodule

// File: rtl/gamma_key_gen.sv
// Keystream source: seeded Galois LFSR delivering one SIZE-bit key word per
// valid/ready transfer, with seed warm-up and a mandatory re-key limit.
module gamma_key_gen
  import gen_gamma_pkg::*;
#(
  parameter int unsigned        SIZE         = 8,
  parameter int unsigned        LFSR_W       = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0]  TAPS         = DEF_TAPS,
  parameter int unsigned        WARMUP       = 4,
  parameter int unsigned        REKEY_PERIOD = 256
) (
  input  logic                                clk,
  input  logic                                res,
  input  logic                                seed_load,
  input  logic [LFSR_W-1:0]                   seed,
  input  logic                                key_ready,
  output logic                                key_valid,
  output logic [SIZE-1:0]                     noise_key,
  output logic [$clog2(REKEY_PERIOD+1)-1:0]   key_idx,
  output logic                                rekey_req,
  output logic                                seed_zero
);

  localparam int unsigned       IDX_W     = $clog2(REKEY_PERIOD+1);
  localparam int unsigned       WCNT_W    = (WARMUP == 0) ? 1 : $clog2(WARMUP+1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(REKEY_PERIOD);
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP);

  gamma_state_t      state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nx, seed_fix;
  logic [SIZE-1:0]   key_q, key_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              valid_q, valid_d;
  logic              rekey_q, rekey_d;
  logic              zero_q, zero_d;
  logic              xfer, warm_done, last_xfer;

  lfsr_word_step #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SIZE   (SIZE)
  ) u_step (
    .state_i (lfsr_q),
    .state_o (lfsr_nx)
  );

  assign seed_fix  = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
  assign xfer      = (state_q == RUN) && valid_q && key_ready;
  assign idx_inc   = idx_q + 1'b1;
  assign warm_done = (wcnt_q == WARM_LAST);
  assign last_xfer = xfer && (idx_inc == IDX_LAST);

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = WARM;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        WARM:    if (warm_done) state_d = RUN;
        RUN:     if (last_xfer) state_d = EXPIRED;
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  // A seed load overrides any transfer presented in the same cycle.
  always_comb begin
    lfsr_d  = lfsr_q;
    key_d   = key_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    valid_d = valid_q;
    rekey_d = rekey_q;
    zero_d  = zero_q;
    if (seed_load) begin
      lfsr_d  = seed_fix;
      idx_d   = '0;
      wcnt_d  = '0;
      valid_d = 1'b0;
      rekey_d = 1'b0;
      zero_d  = zero_q | (seed == '0);
    end else begin
      unique case (state_q)
        WARM: begin
          lfsr_d = lfsr_nx;
          wcnt_d = wcnt_q + 1'b1;
          if (warm_done) begin
            key_d   = lfsr_nx[SIZE-1:0];
            valid_d = 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            idx_d = idx_inc;
            if (last_xfer) begin
              valid_d = 1'b0;
              rekey_d = 1'b1;
            end else begin
              lfsr_d = lfsr_nx;
              key_d  = lfsr_nx[SIZE-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      lfsr_q  <= '0;
      key_q   <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
      rekey_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      valid_q <= valid_d;
      rekey_q <= rekey_d;
      zero_q  <= zero_d;
    end
  end

  assign key_valid = valid_q;
  assign noise_key = key_q;
  assign key_idx   = idx_q;
  assign rekey_req = rekey_q;
  assign seed_zero = zero_q;

endmodule
